// File: rtl/conv_1d_line_loader_if.sv
// conv_1d_line_loader_if: pixel-stream input and line-bus output of the line loader.
interface conv_1d_line_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_D      = 8
);
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH*IMG_D-1:0]       in_data;
    logic                              in_last;
    logic [DATA_WIDTH*IMG_D*IMG_W-1:0] lines_out;
    logic                              out_valid;
    logic                              out_ready;
    logic [7:0]                        opaque_out;
    logic                              err_short;
    logic                              err_long;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, lines_out, out_valid, opaque_out, err_short, err_long
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, lines_out, out_valid, opaque_out, err_short, err_long
    );
endinterface

// File: rtl/conv_1d_line_loader.sv
// conv_1d_line_loader: packs a pixel stream into whole lines, one fill buffer plus one holding register.
module conv_1d_line_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_W       = 32,
    parameter int IMG_D       = 8,
    parameter int W_CNT_WIDTH = $clog2(IMG_W)
) (
    input logic                   clk,
    input logic                   reset,
    conv_1d_line_loader_if.slave  bus
);
    localparam int LW = DATA_WIDTH * IMG_D * IMG_W;

    typedef enum logic {FILL, FULL} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          fill_q, fill_d, hold_q, hold_d, line_w;
    logic [W_CNT_WIDTH-1:0] w_q, w_d;
    logic [7:0]             cnt_q, cnt_d, tag_q, tag_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic                   take, at_end, closing, free, consume;

    assign take    = bus.in_valid && in_ready_q;
    assign at_end  = (w_q == W_CNT_WIDTH'(IMG_W - 1));
    assign closing = take && (at_end || bus.in_last);
    assign free    = !out_valid_q || bus.out_ready;
    assign consume = out_valid_q && bus.out_ready;

    // Beyond the closing pixel the buffer is already zero, since it is cleared after every close.
    always_comb begin
        line_w = fill_q;
        for (int k = 0; k < IMG_D; k++)
            line_w[(k*IMG_W + int'(w_q))*DATA_WIDTH +: DATA_WIDTH] = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        hold_d      = hold_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        err_short_d = err_short_q || (closing && !at_end);
        err_long_d  = err_long_q || (closing && at_end && !bus.in_last);
        if (take) begin
            w_d    = closing ? '0 : w_q + 1'b1;
            fill_d = (closing && free) ? '0 : line_w;
        end
        if (closing && free) begin
            hold_d      = line_w;
            out_valid_d = 1'b1;
            tag_d       = cnt_q;
            cnt_d       = cnt_q + 8'd1;
        end else if (closing) begin
            state_d = FULL;
        end else if (consume && state_q == FULL) begin
            hold_d      = fill_q;
            fill_d      = '0;
            out_valid_d = 1'b1;
            tag_d       = cnt_q;
            cnt_d       = cnt_q + 8'd1;
            state_d     = FILL;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        in_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FILL;
            fill_q      <= '0;
            hold_q      <= '0;
            w_q         <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            hold_q      <= hold_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.lines_out  = hold_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.opaque_out = tag_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_long   = err_long_q;
endmodule

// File: tb/tb_conv_1d_line_loader.sv
// tb_conv_1d_line_loader: scoreboard bench; a line model predicts each emitted line and its tag.
module tb_conv_1d_line_loader;
    localparam int DW = 8;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int LW = DW * D * W;

    typedef struct {
        logic [LW-1:0] line;
        logic [7:0]    tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_consumed = 0;
    int   stalls = 0;
    int   cyc = 0;
    bit   watch = 1'b0;

    exp_t          q[$];
    logic [LW-1:0] m_fill = '0;
    int            m_w = 0;
    logic [7:0]    m_tag = '0;

    conv_1d_line_loader_if #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_D(D)) bus ();

    conv_1d_line_loader #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_D(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are stable at the falling edge, so what is seen here is what the DUT takes at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            m_fill = '0;
            m_w    = 0;
            m_tag  = '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_consumed++;
                if (q.size() == 0) begin
                    check("unexpected_line", 64'(bus.out_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("tag", 64'(bus.opaque_out), 64'(e.tag));
                    for (int i = 0; i < D * W; i++)
                        check("elem", 64'(bus.lines_out[i*DW +: DW]), 64'(e.line[i*DW +: DW]));
                end
            end
            if (watch && bus.in_valid && !bus.in_ready) stalls++;
            if (bus.in_valid && bus.in_ready) begin
                for (int k = 0; k < D; k++)
                    m_fill[(k*W + m_w)*DW +: DW] = bus.in_data[k*DW +: DW];
                if (m_w == W - 1 || bus.in_last) begin
                    q.push_back('{line: m_fill, tag: m_tag});
                    m_tag  = m_tag + 8'd1;
                    m_fill = '0;
                    m_w    = 0;
                end else begin
                    m_w++;
                end
            end
        end
    end

    task automatic send_beat(input logic [DW*D-1:0] d, input logic last);
        int   n = 0;
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("beat_timeout", 64'(ok), 64'(1));
    endtask

    task automatic send_line(input int n, input int last_at, input int seed);
        logic [DW*D-1:0] d;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < D; k++) d[k*DW +: DW] = 8'(seed + w*8 + k);
            send_beat(d, w == last_at);
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while ((q.size() > 0 || bus.out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(q.size()), 64'(0));
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_lines", 64'(|bus.lines_out), 64'(0));
        check("rst_opaque", 64'(bus.opaque_out), 64'(0));
        check("rst_err_short", 64'(bus.err_short), 64'(0));
        check("rst_err_long", 64'(bus.err_long), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(bus.in_ready), 64'(1));

        // single full line, element (k,w) = w*8+k
        bus.out_ready = 1'b1;
        send_line(32, 31, 0);
        bus.in_valid = 1'b0;
        check("t1_out_valid", 64'(bus.out_valid), 64'(1));
        check("t1_opaque", 64'(bus.opaque_out), 64'(0));
        check("t1_err_short", 64'(bus.err_short), 64'(0));
        check("t1_err_long", 64'(bus.err_long), 64'(0));
        drain();

        // backpressure: two lines with out_ready low reach FULL
        do_reset();
        bus.out_ready = 1'b0;
        send_line(32, 31, 3);
        send_line(32, 31, 7);
        bus.in_valid = 1'b0;
        check("t2_full_in_ready", 64'(bus.in_ready), 64'(0));
        check("t2_full_valid", 64'(bus.out_valid), 64'(1));
        check("t2_full_opaque", 64'(bus.opaque_out), 64'(0));
        @(posedge clk);
        #1;
        check("t2_hold_opaque", 64'(bus.opaque_out), 64'(0));
        check("t2_hold_in_ready", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("t2_next_opaque", 64'(bus.opaque_out), 64'(1));
        check("t2_next_valid", 64'(bus.out_valid), 64'(1));
        check("t2_next_in_ready", 64'(bus.in_ready), 64'(1));
        drain();

        // short line closed by in_last at w=9, then a good line
        send_line(10, 9, 11);
        check("t3_err_short", 64'(bus.err_short), 64'(1));
        check("t3_err_long", 64'(bus.err_long), 64'(0));
        send_line(32, 31, 5);
        bus.in_valid = 1'b0;
        drain();
        check("t3_err_short_sticky", 64'(bus.err_short), 64'(1));

        // long line: no in_last at all, next pixel starts a new line
        send_line(32, -1, 9);
        check("t4_err_long", 64'(bus.err_long), 64'(1));
        send_line(32, 31, 13);
        bus.in_valid = 1'b0;
        drain();

        // 256 back-to-back lines with continuous valid and ready
        stalls = 0;
        watch  = 1'b1;
        n0 = n_consumed;
        c0 = cyc;
        for (int l = 0; l < 256; l++) send_line(32, 31, l);
        check("t5_cycles", 64'(cyc - c0), 64'(256 * 32));
        bus.in_valid = 1'b0;
        watch = 1'b0;
        drain();
        check("t5_stalls", 64'(stalls), 64'(0));
        check("t5_lines", 64'(n_consumed - n0), 64'(256));

        // reset at w=15 with a held line pending
        bus.out_ready = 1'b0;
        send_line(32, 31, 17);
        send_line(15, -1, 21);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_valid", 64'(bus.out_valid), 64'(0));
        check("t6_rst_lines", 64'(|bus.lines_out), 64'(0));
        check("t6_rst_opaque", 64'(bus.opaque_out), 64'(0));
        check("t6_rst_err", 64'({bus.err_short, bus.err_long}), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_line(32, 31, 23);
        bus.in_valid = 1'b0;
        check("t6_valid", 64'(bus.out_valid), 64'(1));
        check("t6_opaque", 64'(bus.opaque_out), 64'(0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_1d_line_loader.md
Name: conv_1d_line_loader

Overview:
- Input-side feeder for the fully parallel 1-D convolution datapath, which consumes a whole image line per cycle.
- Accepts a pixel stream over a valid/ready handshake, one pixel with all IMG_D channels per beat.
- Assembles the pixels into the flat line bus the convolution expects and presents each completed line with an 8-bit opaque tag.
- Buffering is one fill buffer plus one holding register, so filling line N+1 overlaps presentation of line N.

Parameters:
DATA_WIDTH  8   bits per channel element
IMG_W  32   pixels per line
IMG_D  8   channels per pixel
W_CNT_WIDTH  $clog2(IMG_W)   width of pixel index counter (derived, not set manually)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (asserted when 0)
in_valid  input  1  input pixel valid
in_ready  output  1  loader can accept a pixel
in_data  input  DATA_WIDTH*IMG_D  pixel; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
in_last  input  1  final pixel of the line
lines_out  output  DATA_WIDTH*IMG_D*IMG_W  assembled line; element (k,w) at bits [(k*IMG_W+w)*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  lines_out/opaque_out hold a line
out_ready  input  1  consumer takes the line
opaque_out  output  8  line sequence tag of the presented line
err_short  output  1  sticky: a line closed early by in_last
err_long  output  1  sticky: in_last absent on pixel IMG_W-1

Behaviour:
- Clocking and reset
  - Single clock; all state updates on the rising edge of clk.
  - While reset==0 at an edge: out_valid=0, lines_out=0, opaque_out=0, err_short=0, err_long=0, line counter=0, pixel index w=0, state=FILL, fill buffer cleared, and in_ready=0 for that cycle.
  - Any partial line or held line is discarded on reset, including reset mid-line.
  - in_ready=1 from the first cycle after reset releases.
- Handshakes
  - A beat transfers when in_valid && in_ready. Its channel k is written into fill-buffer element (k,w), then w increments.
  - A line is consumed when out_valid && out_ready. Holding-register contents and opaque_out stay stable while out_valid=1 and out_ready=0.
- Line close: happens on the accepting edge of pixel w==IMG_W-1, or of any pixel with in_last=1, whichever comes first.
  - Fill-buffer elements with index greater than the closing pixel read as 0 in the emitted line. Zero-padding applies to every channel.
  - Closing beat with w<IMG_W-1 and in_last=1: set err_short.
  - Closing beat with w==IMG_W-1 and in_last=0: set err_long; the line is still emitted.
  - in_last=1 at w==IMG_W-1 is the normal case; no flag.
  - After close, w returns to 0 and the fill buffer is cleared.
- Transfer to the holding register: the holding register is free when out_valid==0, or when out_valid && out_ready in the same cycle.
  - If the register is free at close, the completed line (including the closing beat) loads on that same edge.
  - On that load, out_valid=1 and opaque_out=line counter, then the counter increments (8-bit, wraps 255->0).
  - Latency: closing beat accepted at edge N -> out_valid=1 after edge N.
- State machine
  - FILL: in_ready=1.
    - Close with holding register free: load it, stay in FILL.
    - Close with holding register busy: go to FULL.
  - FULL: in_ready=0; the completed line is kept in the fill buffer.
    - When out_ready && out_valid: load the holding register from the fill buffer on that edge, clear the fill buffer, return to FILL.
    - in_ready is 1 again on the next cycle.
- out_valid drops to 0 on a consume edge with nothing to load.
- Back-to-back operation: with out_ready tied to 1, the loader sustains one pixel per cycle with no bubbles. Lines appear every IMG_W cycles.

Test Plan:
- Reset then a stream of 32 pixels, pixel w channel k = w*8+k (mod 256), in_last on w=31, out_ready=1 -> out_valid=1 after the last edge; element (k,w) equals the input value; opaque_out=0; both error flags 0.
- out_ready=0 while sending two full lines -> after line 2 closes, state is FULL and in_ready=0. Raise out_ready for 1 cycle -> line 1 (tag 0) leaves, line 2 (tag 1) loads, in_ready=1 next cycle.
- in_last on w=9 -> elements w=10..31 are 0 in every channel; err_short=1 and stays 1 across later good lines.
- 32 pixels with in_last=0 throughout -> line emitted, err_long=1, the next pixel goes to w=0 of the next line.
- 256 lines with continuous valid and ready -> no in_ready deassertion; opaque_out wraps 255->0; one out_valid per 32 cycles.
- Assert reset=0 at w=15 with a held line pending -> out_valid=0, outputs 0. After release, a fresh 32-pixel line emits with tag 0 and no stale data.
